// File: rtl/exec_mem_stage.sv
// Execute/memory stage of the single-cycle LEGv8 datapath: ALU-control decode,
// 64-bit ALU with zero flag, and a byte-addressed big-endian data memory.
module exec_mem_stage #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic [1:0]  ALUOp,
    input  logic [10:0] Opcode,
    input  logic [63:0] BusA,
    input  logic [63:0] BusB,
    input  logic [63:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [3:0]  ALUCtrl,
    output logic [63:0] ALUResult,
    output logic        Zero,
    output logic [63:0] ReadData
);

    localparam int AW = $clog2(MEM_BYTES);

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_ORR   = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_LSL   = 4'b0011,
        ALU_LSR   = 4'b0100,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111,
        ALU_BAD   = 4'b1111
    } alu_op_e;

    alu_op_e alu_ctrl;

    always_comb begin
        // NOTE: default assigned first so every path drives alu_ctrl and no latch is inferred.
        alu_ctrl = ALU_BAD;
        case (ALUOp)
            2'b00: alu_ctrl = ALU_ADD;
            2'b01: alu_ctrl = ALU_PASSB;
            2'b10: begin
                casez (Opcode)
                    11'b10001011000: alu_ctrl = ALU_ADD;
                    11'b11001011000: alu_ctrl = ALU_SUB;
                    11'b10001010000: alu_ctrl = ALU_AND;
                    11'b10101010000: alu_ctrl = ALU_ORR;
                    11'b11010011011: alu_ctrl = ALU_LSL;
                    11'b11010011010: alu_ctrl = ALU_LSR;
                    11'b1001000100?: alu_ctrl = ALU_ADD;   // immediate forms ignore bit 21
                    11'b1101000100?: alu_ctrl = ALU_SUB;
                    11'b1001001000?: alu_ctrl = ALU_AND;
                    11'b1011001000?: alu_ctrl = ALU_ORR;
                    default:         alu_ctrl = ALU_BAD;
                endcase
            end
            default: alu_ctrl = ALU_BAD;
        endcase
    end

    assign ALUCtrl = alu_ctrl;

    always_comb begin
        ALUResult = '0;
        case (alu_ctrl)
            ALU_AND:   ALUResult = BusA & BusB;
            ALU_ORR:   ALUResult = BusA | BusB;
            ALU_ADD:   ALUResult = BusA + BusB;
            ALU_SUB:   ALUResult = BusA - BusB;
            ALU_PASSB: ALUResult = BusB;
            ALU_LSL:   ALUResult = BusA << BusB[5:0];
            ALU_LSR:   ALUResult = BusA >> BusB[5:0];
            default:   ALUResult = '0;
        endcase
    end

    assign Zero = ~|ALUResult;

    // Byte i of the doubleword lives at (base + i) mod MEM_BYTES; wrap falls out of AW-bit adds.
    logic [7:0]    mem [MEM_BYTES];
    logic [AW-1:0] base;
    logic [AW-1:0] byte_addr [8];

    assign base = ALUResult[AW-1:0];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            byte_addr[i] = base + AW'(i);
        end
    end

    // NOTE: the memory array is reset here because the stage must read back zeros
    // immediately after Reset_L falls; sequential state uses non-blocking assignments.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem[i] <= '0;
            end
        end else if (MemWrite) begin
            for (int i = 0; i < 8; i++) begin
                mem[byte_addr[i]] <= WriteData[63-8*i -: 8];
            end
        end
    end

    always_comb begin
        ReadData = '0;
        if (MemRead) begin
            for (int i = 0; i < 8; i++) begin
                ReadData[63-8*i -: 8] = mem[byte_addr[i]];
            end
        end
    end

endmodule

// File: tb/tb_exec_mem_stage.sv
// Directed bench for exec_mem_stage: ALU decode/ops, big-endian memory, wrap-around, reset.
module tb_exec_mem_stage;

    localparam int MEM_BYTES = 1024;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_ADDI = 11'b10010001001;
    localparam logic [10:0] OP_SUBI = 11'b11010001000;
    localparam logic [10:0] OP_ORRI = 11'b10110010001;
    localparam logic [10:0] OP_BAD  = 11'b11111111111;

    logic        CLK = 1'b0;
    logic        Reset_L;
    logic [1:0]  ALUOp;
    logic [10:0] Opcode;
    logic [63:0] BusA, BusB, WriteData;
    logic        MemRead, MemWrite;
    logic [3:0]  ALUCtrl;
    logic [63:0] ALUResult;
    logic        Zero;
    logic [63:0] ReadData;

    int checks = 0;
    int errors = 0;

    exec_mem_stage #(.MEM_BYTES(MEM_BYTES)) dut (
        .CLK       (CLK),
        .Reset_L   (Reset_L),
        .ALUOp     (ALUOp),
        .Opcode    (Opcode),
        .BusA      (BusA),
        .BusB      (BusB),
        .WriteData (WriteData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .ALUCtrl   (ALUCtrl),
        .ALUResult (ALUResult),
        .Zero      (Zero),
        .ReadData  (ReadData)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%016h expected=0x%016h", tag, obs, exp);
        end
    endtask

    task automatic alu(input logic [1:0] op, input logic [10:0] opc,
                       input logic [63:0] a, input logic [63:0] b);
        ALUOp  = op;
        Opcode = opc;
        BusA   = a;
        BusB   = b;
        #1;
    endtask

    // Address = a + b via ALUOp=00; store spans exactly one rising edge.
    task automatic store(input logic [63:0] addr, input logic [63:0] data);
        @(negedge CLK);
        alu(2'b00, 11'd0, addr, 64'd0);
        WriteData = data;
        MemWrite  = 1'b1;
        @(posedge CLK);
        #1;
        MemWrite  = 1'b0;
    endtask

    task automatic load(input logic [63:0] addr);
        @(negedge CLK);
        alu(2'b00, 11'd0, addr, 64'd0);
        MemRead = 1'b1;
        #1;
    endtask

    initial begin
        Reset_L   = 1'b0;
        ALUOp     = 2'b00;
        Opcode    = '0;
        BusA      = '0;
        BusB      = '0;
        WriteData = '0;
        MemRead   = 1'b1;
        MemWrite  = 1'b0;
        #12;
        check("reset_read", ReadData, 64'd0);
        Reset_L = 1'b1;
        load(64'h18);
        check("post_reset_read", ReadData, 64'd0);
        MemRead = 1'b0;

        // R-type operations
        alu(2'b10, OP_ADD, 64'd5, 64'd7);
        check("add_ctrl", 64'(ALUCtrl), 64'h2);
        check("add_res",  ALUResult, 64'd12);
        check("add_zero", 64'(Zero), 64'd0);
        alu(2'b10, OP_SUB, 64'h1234, 64'h1234);
        check("sub_ctrl", 64'(ALUCtrl), 64'h6);
        check("sub_res",  ALUResult, 64'd0);
        check("sub_zero", 64'(Zero), 64'd1);
        alu(2'b10, OP_AND, 64'hF0F0, 64'hFF00);
        check("and_ctrl", 64'(ALUCtrl), 64'h0);
        check("and_res",  ALUResult, 64'hF000);
        alu(2'b10, OP_ORR, 64'hF0F0, 64'hFF00);
        check("orr_ctrl", 64'(ALUCtrl), 64'h1);
        check("orr_res",  ALUResult, 64'hFFF0);
        alu(2'b10, OP_LSL, 64'd1, 64'd63);
        check("lsl_ctrl", 64'(ALUCtrl), 64'h3);
        check("lsl_res",  ALUResult, 64'h8000_0000_0000_0000);
        alu(2'b10, OP_LSR, 64'h8000_0000_0000_0000, 64'd4);
        check("lsr_ctrl", 64'(ALUCtrl), 64'h4);
        check("lsr_res",  ALUResult, 64'h0800_0000_0000_0000);
        // Shift amount uses only B[5:0]: 64+2 shifts by 2
        alu(2'b10, OP_LSL, 64'd3, 64'd66);
        check("lsl_mod64", ALUResult, 64'd12);

        // Immediate forms, bit 21 is don't-care
        alu(2'b10, OP_ADDI, 64'd100, 64'hFFFF_FFFF_FFFF_FFFF);
        check("addi_ctrl", 64'(ALUCtrl), 64'h2);
        check("addi_res",  ALUResult, 64'd99);
        alu(2'b10, OP_SUBI, 64'd0, 64'd1);
        check("subi_wrap", ALUResult, 64'hFFFF_FFFF_FFFF_FFFF);
        alu(2'b10, OP_ORRI, 64'h0F, 64'hF0);
        check("orri_ctrl", 64'(ALUCtrl), 64'h1);
        check("orri_res",  ALUResult, 64'hFF);

        // CBZ pass-B
        alu(2'b01, OP_BAD, 64'd77, 64'd0);
        check("cbz0_ctrl", 64'(ALUCtrl), 64'h7);
        check("cbz0_zero", 64'(Zero), 64'd1);
        alu(2'b01, OP_BAD, 64'd77, 64'd9);
        check("cbz9_res",  ALUResult, 64'd9);
        check("cbz9_zero", 64'(Zero), 64'd0);

        // Undefined decodes
        alu(2'b10, OP_BAD, 64'd5, 64'd7);
        check("bad_ctrl", 64'(ALUCtrl), 64'hF);
        check("bad_res",  ALUResult, 64'd0);
        check("bad_zero", 64'(Zero), 64'd1);
        alu(2'b11, OP_ADD, 64'd5, 64'd7);
        check("op11_ctrl", 64'(ALUCtrl), 64'hF);
        check("op11_res",  ALUResult, 64'd0);

        // Store then load, address = 0x10 + 0x8
        @(negedge CLK);
        alu(2'b00, 11'd0, 64'h10, 64'h8);
        check("ldst_ctrl", 64'(ALUCtrl), 64'h2);
        check("ldst_addr", ALUResult, 64'h18);
        WriteData = 64'h0123_4567_89AB_CDEF;
        MemWrite  = 1'b1;
        @(posedge CLK);
        #1;
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        #1;
        check("load_18", ReadData, 64'h0123_4567_89AB_CDEF);
        load(64'h11);
        check("load_11_unaligned", ReadData, 64'h0000_0000_0000_0001);
        load(64'h1C);
        check("load_1C_unaligned", ReadData, 64'h89AB_CDEF_0000_0000);

        // Simultaneous read/write: old data before the edge, new after
        @(negedge CLK);
        alu(2'b00, 11'd0, 64'h18, 64'd0);
        WriteData = 64'hCAFE_F00D_1111_2222;
        MemWrite  = 1'b1;
        MemRead   = 1'b1;
        #1;
        check("rw_before_edge", ReadData, 64'h0123_4567_89AB_CDEF);
        @(posedge CLK);
        #1;
        MemWrite = 1'b0;
        check("rw_after_edge", ReadData, 64'hCAFE_F00D_1111_2222);

        // Wrap-around at the top of memory; address high bits beyond AW are ignored
        store(64'(MEM_BYTES - 4), 64'hA1A2_A3A4_B1B2_B3B4);
        load(64'(MEM_BYTES - 4));
        check("wrap_full", ReadData, 64'hA1A2_A3A4_B1B2_B3B4);
        load(64'd0);
        check("wrap_low", ReadData, 64'hB1B2_B3B4_0000_0000);
        load(64'(MEM_BYTES) + 64'h18);
        check("addr_modulo", ReadData, 64'hCAFE_F00D_1111_2222);

        // MemRead low gates the read data
        MemRead = 1'b0;
        #1;
        check("memread_low", ReadData, 64'd0);

        // Asynchronous reset between edges clears memory
        store(64'd0, 64'h0000_0000_DEAD_BEEF);
        load(64'd0);
        check("pre_reset", ReadData, 64'h0000_0000_DEAD_BEEF);
        #2;
        Reset_L = 1'b0;
        #1;
        check("reset_async", ReadData, 64'd0);
        WriteData = 64'h5555_5555_5555_5555;
        MemWrite  = 1'b1;
        @(posedge CLK);
        #1;
        check("reset_blocks_write", ReadData, 64'd0);
        MemWrite = 1'b0;
        @(negedge CLK);
        Reset_L = 1'b1;
        #1;
        check("after_reset_0", ReadData, 64'd0);
        load(64'h18);
        check("after_reset_18", ReadData, 64'd0);

        // Memory writable again after reset
        store(64'h40, 64'h0102_0304_0506_0708);
        load(64'h40);
        check("post_reset_store", ReadData, 64'h0102_0304_0506_0708);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exec_mem_stage.md
Name: exec_mem_stage

Overview:
- Execute/memory stage of the single-cycle 64-bit LEGv8 datapath.
- Combines three functions:
  - ALU-control decode of ALUOp and the 11-bit opcode.
  - A 64-bit ALU with a zero flag.
  - A byte-addressed, big-endian data memory.
- Sits between the register file / immediate mux and the MemToReg writeback mux.
- Provides the address/data path for LDUR/STUR and the zero flag for CBZ.

Parameters:
- MEM_BYTES, 1024: data memory size in bytes. Must be a power of two, at least 8.

Ports:
- CLK  in  1  clock; memory writes occur on the rising edge.
- Reset_L  in  1  asynchronous, active-low reset.
- ALUOp  in  2  operation class from main control.
- Opcode  in  11  instruction bits [31:21].
- BusA  in  64  ALU operand A (register Rn).
- BusB  in  64  ALU operand B (register or sign-extended immediate, already muxed).
- WriteData  in  64  store data (register Rt).
- MemRead  in  1  read enable.
- MemWrite  in  1  write enable.
- ALUCtrl  out  4  decoded ALU operation.
- ALUResult  out  64  ALU result; also the memory byte address.
- Zero  out  1  high when ALUResult == 0.
- ReadData  out  64  memory read data.

Behaviour:

ALU control (combinational):
- ALUOp=00 → 0010 (ADD; load/store address).
- ALUOp=01 → 0111 (pass B; CBZ).
- ALUOp=10 → decode by Opcode:
  - 10001011000 ADD → 0010
  - 11001011000 SUB → 0110
  - 10001010000 AND → 0000
  - 10101010000 ORR → 0001
  - 11010011011 LSL → 0011
  - 11010011010 LSR → 0100
  - 1001000100x ADDI → 0010
  - 1101000100x SUBI → 0110
  - 1001001000x ANDI → 0000
  - 1011001000x ORRI → 0001
  - any other opcode → 1111
- ALUOp=11 → 1111.

ALU (combinational, 64-bit, wrap-around arithmetic, no carry or overflow outputs):
- 0000: A & B
- 0001: A | B
- 0010: A + B
- 0110: A − B
- 0111: B
- 0011: A << B[5:0]
- 0100: A >> B[5:0], logical
- any other code: result 0
- Zero = ~|ALUResult, for every operation including undefined codes.

Data memory:
- Array of MEM_BYTES bytes, byte-addressed.
- Effective address a = ALUResult modulo MEM_BYTES.
- A doubleword covers bytes a..a+7; each byte index also wraps modulo MEM_BYTES.
- Big-endian: byte a maps to bits [63:56], byte a+7 maps to bits [7:0].
- Unaligned addresses are allowed.
- Read (combinational): ReadData = doubleword at a when MemRead=1; ReadData = 0 when MemRead=0.
- Write: on the rising CLK edge with MemWrite=1 and Reset_L=1, the 8 bytes at a take WriteData.
  - The new value is visible to a combinational read after that edge.
  - Before the edge, a read at the same address returns the old data.
- MemRead=1 and MemWrite=1 together are legal: the read shows the old data until the edge, then the new data.
- Reset: while Reset_L=0, all bytes are cleared to 0 asynchronously and writes are ignored.
  - Reset asserted mid-operation discards any pending write.
  - ReadData follows the cleared contents, i.e. 0.
- No other state exists. ALUCtrl, ALUResult and Zero are purely combinational, unaffected by reset.

Test Plan:
- ALUOp=10, Opcode=ADD, A=5, B=7 → ALUCtrl=0010, ALUResult=12, Zero=0.
- ALUOp=10, Opcode=SUB, A=B=0x1234 → ALUCtrl=0110, ALUResult=0, Zero=1.
- Remaining R-type operations:
  - AND with A=0xF0F0, B=0xFF00 → 0xF000.
  - ORR with the same operands → 0xFFF0.
  - LSL with A=1, B=63 → 0x8000000000000000.
  - LSR with A=0x8000000000000000, B=4 → 0x0800000000000000.
  - ALUOp=01, B=0 → Zero=1.
  - ALUOp=01, B=9 → ALUResult=9.
- Store then load:
  - ALUOp=00, A=0x10, B=0x8, WriteData=0x0123456789ABCDEF, MemWrite=1 for one edge.
  - Then MemRead=1 → ReadData=0x0123456789ABCDEF.
  - Byte 0x18 holds 0x01 (verify with an unaligned read at 0x11, which returns 0x0000000000000001).
- Wrap-around: write at address MEM_BYTES−4 → the last 4 bytes land at the top of memory and the remaining 4 at bytes 0..3.
  - A read at MEM_BYTES−4 returns the full value.
  - A read at 0 returns the low word in bits [63:32].
- Reset:
  - Write 0xDEADBEEF at address 0, pulse Reset_L low between edges → ReadData at address 0 becomes 0 immediately.
  - MemWrite=1 on an edge during reset → no write.
  - MemRead=0 → ReadData=0.
  - Undefined Opcode with ALUOp=10 → ALUCtrl=1111, ALUResult=0, Zero=1.
